// File: rtl/dec_gpr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec_gpr_pkg
// Description : Shared GPR geometry for the write-back arbiter, the pending
//               write scoreboard and the GPR file.
//               GPR_AW    - GPR index width
//               NGPR      - number of architectural GPRs
//               gpr_idx_t - GPR index type
// Revision    : 1.0 - initial release
// ============================================================================
package dec_gpr_pkg;

  localparam int GPR_AW = 5;
  localparam int NGPR   = 32;

  typedef logic [GPR_AW-1:0] gpr_idx_t;

endpackage
`default_nettype wire

// File: rtl/dec_gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : dec_gpr_scoreboard
// Description : Pending-write scoreboard for the GPR file. One busy bit per
//               GPR (x0 is never busy). Decode sets a bit at issue and the
//               write stage clears it on commit. Two read-side lookups report
//               whether a source operand still has a write outstanding.
// Ports       : clk, rst_l            - clock, async active-low reset
//               set_en, set_addr      - issue of a GPR-writing instruction
//               clr_en, clr_addr      - committed write (wen0/waddr0)
//               chk_addr0/1           - lookup addresses
//               chk_busy0/1           - lookup results
// Revision    : 1.0 - initial release
// ============================================================================
module dec_gpr_scoreboard
  import dec_gpr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_l,
  input  logic              set_en,
  input  logic [GPR_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [GPR_AW-1:0] clr_addr,
  input  logic [GPR_AW-1:0] chk_addr0,
  input  logic [GPR_AW-1:0] chk_addr1,
  output logic              chk_busy0,
  output logic              chk_busy1
);

  logic [NGPR-1:1] r_busy;
  logic [NGPR-1:1] w_busy_nxt;
  logic [NGPR-1:0] w_busy_full;
  logic            w_set_live;

  // x0 is architecturally constant, so a set to it is ignored everywhere.
  assign w_set_live  = set_en && (set_addr != '0);
  assign w_busy_full = {r_busy, 1'b0};

  // A same-cycle set beats a clear: the set belongs to a newer instruction
  // whose write has not happened yet.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NGPR; i++) begin
      if (w_set_live && (set_addr == gpr_idx_t'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (clr_en && (clr_addr == gpr_idx_t'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Forward the same-cycle issue so a dependent lookup in the issue cycle
  // already sees the hazard. Committing writes are not bypassed.
  always_comb begin
    chk_busy0 = w_busy_full[chk_addr0] | (w_set_live && (set_addr == chk_addr0));
    chk_busy1 = w_busy_full[chk_addr1] | (w_set_live && (set_addr == chk_addr1));
  end

endmodule
`default_nettype wire

// File: rtl/dec_gpr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : dec_gpr_wb_arb
// Description : Write-back arbiter for the single GPR write port. Port A
//               (integer/load pipe) has fixed priority; port B (FPU) is
//               forced ahead after STARVE_LIM consecutive waiting cycles.
//               The winner is registered into a one-entry write stage that
//               drives the GPR file. Also hosts the pending-write scoreboard.
// Ports       : clk, rst_l               - clock, async active-low reset
//               a_valid/a_ready/a_addr/a_data - port A request
//               b_valid/b_ready/b_addr/b_data - port B request
//               sb_set, sb_addr          - decode issue into the scoreboard
//               chk_addr0/1, chk_busy0/1 - scoreboard lookups
//               wen0, waddr0, wd0        - GPR write port
// Revision    : 1.0 - initial release
// ============================================================================
module dec_gpr_wb_arb
  import dec_gpr_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [GPR_AW-1:0] a_addr,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [GPR_AW-1:0] b_addr,
  input  logic [XLEN-1:0]   b_data,
  input  logic              sb_set,
  input  logic [GPR_AW-1:0] sb_addr,
  input  logic [GPR_AW-1:0] chk_addr0,
  input  logic [GPR_AW-1:0] chk_addr1,
  output logic              chk_busy0,
  output logic              chk_busy1,
  output logic              wen0,
  output logic [GPR_AW-1:0] waddr0,
  output logic [XLEN-1:0]   wd0
);

  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);

  logic [3:0]        r_starve_cnt;
  logic              w_b_forced;
  logic              w_a_grant;
  logic              w_b_grant;
  logic              w_accept;
  logic [GPR_AW-1:0] w_sel_addr;
  logic [XLEN-1:0]   w_sel_data;
  logic              r_wen;
  logic [GPR_AW-1:0] r_waddr;
  logic [XLEN-1:0]   r_wd;

  // Grant: A unless B has waited long enough, in which case B jumps ahead.
  assign w_b_forced = b_valid && (r_starve_cnt == c_starve_lim);
  assign w_b_grant  = b_valid && (!a_valid || w_b_forced);
  assign w_a_grant  = a_valid && !w_b_grant;
  assign w_accept   = w_a_grant || w_b_grant;
  assign a_ready    = w_a_grant;
  assign b_ready    = w_b_grant;

  assign w_sel_addr = w_b_grant ? b_addr : a_addr;
  assign w_sel_data = w_b_grant ? b_data : a_data;

  // Counts consecutive cycles B spends waiting; saturates at the limit and
  // restarts whenever B is served or withdraws.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_starve_cnt <= '0;
    end else if (b_valid && !w_b_grant) begin
      if (r_starve_cnt != c_starve_lim) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Write stage. An accepted x0 write is consumed but never enabled.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wd    <= '0;
    end else begin
      r_wen <= w_accept && (w_sel_addr != '0);
      if (w_accept) begin
        r_waddr <= w_sel_addr;
        r_wd    <= w_sel_data;
      end
    end
  end

  assign wen0   = r_wen;
  assign waddr0 = r_waddr;
  assign wd0    = r_wd;

  dec_gpr_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_l     (rst_l),
    .set_en    (sb_set),
    .set_addr  (sb_addr),
    .clr_en    (r_wen),
    .clr_addr  (r_waddr),
    .chk_addr0 (chk_addr0),
    .chk_addr1 (chk_addr1),
    .chk_busy0 (chk_busy0),
    .chk_busy1 (chk_busy1)
  );

endmodule
`default_nettype wire

// File: tb/tb_dec_gpr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_gpr_wb_arb
// Description : Self-checking bench for dec_gpr_wb_arb. A behavioural model
//               (busy set, pending write, waiting-cycle count) is compared
//               against the DUT on every falling edge; directed scenarios
//               add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_gpr_wb_arb;

  localparam int XLEN       = 32;
  localparam int STARVE_LIM = 4;

  logic            clk = 1'b0;
  logic            rst_l = 1'b1;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [4:0]      a_addr = '0;
  logic [XLEN-1:0] a_data = '0;
  logic            b_valid = 1'b0;
  logic            b_ready;
  logic [4:0]      b_addr = '0;
  logic [XLEN-1:0] b_data = '0;
  logic            sb_set = 1'b0;
  logic [4:0]      sb_addr = '0;
  logic [4:0]      chk_addr0 = '0;
  logic [4:0]      chk_addr1 = '0;
  logic            chk_busy0;
  logic            chk_busy1;
  logic            wen0;
  logic [4:0]      waddr0;
  logic [XLEN-1:0] wd0;

  int checks = 0;
  int errors = 0;

  dec_gpr_wb_arb #(.XLEN(XLEN), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_l(rst_l),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]       m_busy  = '0;  // bit i = GPR i has a write outstanding
  bit              m_wen   = 1'b0;
  bit [4:0]        m_waddr = '0;
  bit [XLEN-1:0]   m_wd    = '0;
  int              m_wait  = 0;   // cycles B has been waiting in a row
  bit [31:0]       n_busy  = '0;
  bit              n_wen   = 1'b0;
  bit [4:0]        n_waddr = '0;
  bit [XLEN-1:0]   n_wd    = '0;
  int              n_wait  = 0;

  function automatic bit exp_busy(input bit [4:0] c);
    if (c == 0) return 1'b0;
    return m_busy[c] || (sb_set && sb_addr == c);
  endfunction

  // Compare, then work out what the next rising edge must produce.
  always @(negedge clk) begin
    bit   b_wins, a_wins;
    bit [4:0] w_a;
    b_wins = b_valid && (!a_valid || m_wait >= STARVE_LIM);
    a_wins = a_valid && !b_wins;
    check("a_ready", a_ready, a_wins);
    check("b_ready", b_ready, b_wins);
    check("wen0", wen0, m_wen);
    check("waddr0", waddr0, m_waddr);
    check("wd0", wd0, m_wd);
    check("chk_busy0", chk_busy0, exp_busy(chk_addr0));
    check("chk_busy1", chk_busy1, exp_busy(chk_addr1));

    n_busy = m_busy;
    if (m_wen) n_busy[m_waddr] = 1'b0;
    if (sb_set && sb_addr != 0) n_busy[sb_addr] = 1'b1;
    n_busy[0] = 1'b0;
    n_wait  = (b_valid && !b_wins) ? ((m_wait + 1 > STARVE_LIM) ? STARVE_LIM : m_wait + 1) : 0;
    n_wen   = 1'b0;
    n_waddr = m_waddr;
    n_wd    = m_wd;
    if (a_wins || b_wins) begin
      w_a     = b_wins ? b_addr : a_addr;
      n_waddr = w_a;
      n_wd    = b_wins ? b_data : a_data;
      n_wen   = (w_a != 0);
    end
  end

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wd = '0; m_wait = 0;
      n_busy = '0; n_wen = 1'b0; n_waddr = '0; n_wd = '0; n_wait = 0;
    end else begin
      m_busy = n_busy; m_wen = n_wen; m_waddr = n_waddr; m_wd = n_wd; m_wait = n_wait;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc_a, acc_b;
    #1 rst_l = 1'b0;
    #2;
    check("rst wen0", wen0, 1'b0);
    check("rst waddr0", waddr0, 5'd0);
    check("rst wd0", wd0, 32'd0);
    chk_addr0 = 5'd5; chk_addr1 = 5'd31;
    #1;
    check("rst chk_busy0", chk_busy0, 1'b0);
    check("rst chk_busy1", chk_busy1, 1'b0);
    tick(); tick();
    rst_l = 1'b1;
    tick();

    // A only: addr 5, data DEADBEEF, previously issued via sb_set.
    sb_set = 1'b1; sb_addr = 5'd5;
    tick();
    sb_set = 1'b0; chk_addr0 = 5'd5;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("A busy before", chk_busy0, 1'b1);
    check("A a_ready", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    #1;
    check("A wen0", wen0, 1'b1);
    check("A waddr0", waddr0, 5'd5);
    check("A wd0", wd0, 32'hDEADBEEF);
    check("A busy in wen cycle", chk_busy0, 1'b1);
    tick();
    #1;
    check("A wen0 after", wen0, 1'b0);
    check("A busy cleared", chk_busy0, 1'b0);

    // Starvation: B is forced on the 5th waiting cycle.
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_00A1;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_00B7;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("starve b_ready c%0d", k), b_ready, (k == 5));
      check($sformatf("starve a_ready c%0d", k), a_ready, (k != 5));
      tick();
    end
    b_valid = 1'b0;
    #1;
    check("starve wen0", wen0, 1'b1);
    check("starve waddr0", waddr0, 5'd7);
    check("starve wd0", wd0, 32'h0000_00B7);
    check("starve A resumes", a_ready, 1'b1);
    tick();
    a_valid = 1'b0;

    // Mark GPR3 busy, then an x0 write via B leaves it untouched.
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    sb_set = 1'b0; chk_addr0 = 5'd3;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1111_2222;
    #1;
    check("x0 b_ready", b_ready, 1'b1);
    tick();
    b_valid = 1'b0;
    #1;
    check("x0 wen0", wen0, 1'b0);
    check("x0 busy3 kept", chk_busy0, 1'b1);
    tick();

    // Scoreboard race on GPR9.
    sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9999_0009;
    tick();
    a_valid = 1'b0;
    sb_set = 1'b1; sb_addr = 5'd9; chk_addr0 = 5'd9;
    #1;
    check("race wen0", wen0, 1'b1);
    check("race busy9 now", chk_busy0, 1'b1);
    tick();
    sb_set = 1'b0;
    #1;
    check("race busy9 kept", chk_busy0, 1'b1);

    // Same-cycle lookup.
    sb_set = 1'b1; sb_addr = 5'd12; chk_addr1 = 5'd12; chk_addr0 = 5'd0;
    #1;
    check("fwd chk_busy1", chk_busy1, 1'b1);
    check("x0 chk_busy0", chk_busy0, 1'b0);
    tick();
    sb_set = 1'b0;

    // Mixed traffic obeying the hold-until-accepted rule.
    for (int i = 0; i < 40; i++) begin
      if (!a_valid) begin
        a_valid = (i % 3 != 0); a_addr = 5'(i); a_data = 32'hA000_0000 + i;
      end
      if (!b_valid) begin
        b_valid = (i % 5 != 1); b_addr = 5'(i * 3 + 1); b_data = 32'hB000_0000 + i;
      end
      sb_set = (i % 4 == 1); sb_addr = 5'(i * 7);
      chk_addr0 = 5'(i); chk_addr1 = 5'(i * 7);
      #1;
      acc_a = a_ready; acc_b = b_ready;
      tick();
      if (acc_a) a_valid = 1'b0;
      if (acc_b) b_valid = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0; sb_set = 1'b0;
    tick();

    // Async reset with a write in flight and busy bits set.
    sb_set = 1'b1; sb_addr = 5'd4;
    tick();
    sb_set = 1'b0;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h4444_4444;
    tick();
    a_valid = 1'b0; chk_addr0 = 5'd4; chk_addr1 = 5'd12;
    #1;
    check("pre-rst wen0", wen0, 1'b1);
    check("pre-rst busy4", chk_busy0, 1'b1);
    rst_l = 1'b0;
    #1;
    check("async wen0", wen0, 1'b0);
    check("async chk_busy0", chk_busy0, 1'b0);
    check("async chk_busy1", chk_busy1, 1'b0);
    tick();
    rst_l = 1'b1;
    tick();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h1234_5678;
    tick();
    a_valid = 1'b0;
    #1;
    check("post-rst wen0", wen0, 1'b1);
    check("post-rst waddr0", waddr0, 5'd6);
    check("post-rst wd0", wd0, 32'h1234_5678);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec_gpr_wb_arb.md
# dec_gpr_wb_arb

Write-back arbiter and pending-write scoreboard for the integer GPR file. It shares the register file's single write port between two result sources. Port A is the integer/load pipe; port B is the FPU result path. It also tracks which GPRs have an issued-but-uncommitted write, so decode can stall reads. It sits between the execute/FPU result buses and the GPR file's write-enable, write-address and write-data inputs.

## Interface
Parameters:
- XLEN, 32, GPR data width
- STARVE_LIM, 4, consecutive B-waiting cycles (B valid, not granted) before B is forced ahead of A; range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst_l  in  1  reset, asynchronous, active-low
- a_valid  in  1  port A write request
- a_ready  out  1  port A accepted this cycle
- a_addr  in  5  port A destination GPR
- a_data  in  XLEN  port A result
- b_valid  in  1  port B write request
- b_ready  out  1  port B accepted this cycle
- b_addr  in  5  port B destination GPR
- b_data  in  XLEN  port B result
- sb_set  in  1  decode issued an instruction that will write sb_addr
- sb_addr  in  5  destination of the issued instruction
- chk_addr0, chk_addr1  in  5 each  source operands under lookup
- chk_busy0, chk_busy1  out  1 each  lookup address has a pending write
- wen0  out  1  GPR write enable
- waddr0  out  5  GPR write address
- wd0  out  XLEN  GPR write data

## Operation
- Handshake: a request transfers on any cycle with valid & ready. At most one port is ready per cycle.
  - Requesters hold valid, addr and data stable until accepted.
  - The ready outputs depend combinationally on the valid inputs and on state.
- Grant policy: A has fixed priority.
  - starve_cnt increments each cycle that b_valid=1 and B is not granted; it saturates at STARVE_LIM.
  - If starve_cnt==STARVE_LIM and b_valid, B wins even when A is valid.
  - starve_cnt clears whenever B is granted or b_valid=0.
- Write stage: the accepted request is captured into a one-entry output register (wen0/waddr0/wd0).
  - With no acceptance, wen0=0 the next cycle. waddr0/wd0 hold their last value.
  - Addr 0: the request is accepted normally, but wen0 stays 0 (x0 write dropped).
- Scoreboard: busy[31:1], bit 0 is hardwired 0.
  - sb_set=1 with sb_addr≠0 sets busy[sb_addr].
  - A committed write (wen0=1) clears busy[waddr0] at the end of that cycle.
  - Same-cycle set and clear to the same address: set wins, because the newer write is still pending.
- Lookup: chk_busyN = busy[chk_addrN] | (sb_set & sb_addr==chk_addrN & chk_addrN≠0).
  - chk_addrN==0 gives 0.
  - A write in the wen0 stage still reports busy during that cycle; there is no bypass.

## Timing
- Reset values: wen0=0, waddr0=0, wd0=0, busy=0, starve_cnt=0, chk_busy=0 when there is no same-cycle set.
- Latency: acceptance at edge N → wen0=1 during cycle N+1 → GPR updated and busy cleared at edge N+2.
- Throughput: one write per cycle, sustained.
- Reset mid-operation:
  - The captured write is discarded: wen0 drops immediately (asynchronous).
  - All busy bits clear.
  - Requesters must re-issue after reset.

## Structure
- Package dec_gpr_pkg holds GPR_AW=5, NGPR=32 and the 5-bit GPR index type. The arbiter and the GPR file share these.
- Sub-module dec_gpr_scoreboard holds:
  - the busy vector;
  - the set/clear priority logic;
  - the two lookup ports.
- The top level holds the grant logic, starve_cnt and the write-stage register.

## Test plan
- A only: a_valid with addr 5, data 0xDEADBEEF at edge N → a_ready=1; in cycle N+1, wen0=1, waddr0=5, wd0=0xDEADBEEF; busy[5] set earlier via sb_set clears at edge N+2.
- Starvation, STARVE_LIM=4: A valid every cycle, B valid with addr 7 → B is granted on the 5th cycle of waiting; starve_cnt returns to 0; A resumes the next cycle.
- x0 drop: B request with addr 0 → b_ready=1; wen0 stays 0 the next cycle; all busy bits unchanged.
- Scoreboard race: busy[9]=1 and wen0 writing addr 9, with sb_set addr 9 in the same cycle → busy[9] stays 1; chk_addr0=9 returns chk_busy0=1.
- Same-cycle lookup: sb_set addr 12 with chk_addr1=12 in the same cycle → chk_busy1=1 combinationally; chk_addr0=0 → chk_busy0=0.
- Async reset: assert rst_l=0 mid-cycle while wen0=1 and busy is non-zero → wen0=0 and all chk_busy=0 without waiting for a clock edge; after release, a fresh A write completes normally.
